// File: rtl/hft_cfg_pkg.sv
// Shared definitions for the SPI configuration slave.
// Holds the register index map, the exec_mode encodings, the arb_mult reset
// value and the frame FSM state type.
package hft_cfg_pkg;

    // Register index map. The index is carried in command bits [6:0].
    localparam logic [6:0] REG_BUY_LIMIT  = 7'h00;
    localparam logic [6:0] REG_SELL_LIMIT = 7'h01;
    localparam logic [6:0] REG_BUY_QTY    = 7'h02;
    localparam logic [6:0] REG_SELL_QTY   = 7'h03;
    localparam logic [6:0] REG_EXEC_MODE  = 7'h04;
    localparam logic [6:0] REG_ARB_MULT   = 7'h05;

    // Execution modes. Any exec_mode write above MODE_HOST_SELL is rejected.
    typedef enum logic [7:0] {
        MODE_BUILTIN   = 8'h00,
        MODE_HOST_BUY  = 8'h01,
        MODE_HOST_SELL = 8'h02
    } exec_mode_t;

    localparam logic [15:0] ARB_MULT_RST = 16'd16;

    // Frame FSM: 8 command bits (CMD), 32 data bits (DATA), then DONE until
    // chip select goes high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detect for one asynchronous SPI pin.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   async_in   : raw pin from the SPI host
//   rise, fall : one-clk pulses on a synchronized rising / falling edge
// RST_VAL is the pin's idle level so that leaving reset produces no edge
// when the pin is idle. STAGES must be at least 2.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_cfg_slave.sv
// SPI (mode 0) configuration slave for the trading core's host registers.
// A frame is an 8-bit command (bit7 = read, bits[6:0] = index) followed by
// 32 data bits, MSB first. Writes commit one clk after the 40th bit; reads
// return the indexed register on spi_miso during the data phase.
// Ports:
//   clk, rst_n                    : core clock, async active-low reset
//   spi_sclk, spi_cs_n, spi_mosi  : SPI host pins (asynchronous)
//   spi_miso                      : read data, 0 outside a read data phase
//   buy_limit .. arb_mult         : configuration registers
//   cfg_wr_strobe, cfg_wr_addr    : one-clk pulse + index per committed write
//   frame_err                     : sticky error for aborted/invalid frames
module spi_cfg_slave
    import hft_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] buy_limit,
    output logic [31:0] sell_limit,
    output logic [31:0] buy_qty,
    output logic [31:0] sell_qty,
    output logic [7:0]  exec_mode,
    output logic [15:0] arb_mult,
    output logic        cfg_wr_strobe,
    output logic [7:0]  cfg_wr_addr,
    output logic        frame_err
);

    logic                   sclk_rise, sclk_fall;
    logic                   cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    spi_state_t  state_q, state_d;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  cmd_q;
    logic [31:0] data_q;
    logic        commit_q;
    logic        rd_loaded_q;
    logic [31:0] miso_sr_q;
    logic [31:0] rd_word;
    logic [6:0]  cmd_idx;
    logic        cmd_rd;
    logic        wr_ok;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi_sclk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi_cs_n),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // MOSI uses the same depth as SCLK so the synchronized data bit lines up
    // with the synchronized rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign cmd_idx = cmd_q[6:0];
    assign cmd_rd  = cmd_q[7];

    // Read shadow: the live register, zero-extended; unknown indices read 0.
    always_comb begin
        rd_word = '0;
        case (cmd_idx)
            REG_BUY_LIMIT:  rd_word = buy_limit;
            REG_SELL_LIMIT: rd_word = sell_limit;
            REG_BUY_QTY:    rd_word = buy_qty;
            REG_SELL_QTY:   rd_word = sell_qty;
            REG_EXEC_MODE:  rd_word = {24'd0, exec_mode};
            REG_ARB_MULT:   rd_word = {16'd0, arb_mult};
            default:        rd_word = '0;
        endcase
    end

    always_comb begin
        wr_ok = 1'b0;
        case (cmd_idx)
            REG_BUY_LIMIT, REG_SELL_LIMIT,
            REG_BUY_QTY, REG_SELL_QTY,
            REG_ARB_MULT:  wr_ok = 1'b1;
            REG_EXEC_MODE: wr_ok = (data_q[7:0] <= MODE_HOST_SELL);
            default:       wr_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chip-select edges take priority: a rise always ends the frame and a
    // fall always starts a fresh one, whatever state the FSM is in.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else if (cs_fall) begin
            state_d = CMD;
        end else if (sclk_rise) begin
            if (state_q == CMD && bit_cnt_q == 5'd7) begin
                state_d = DATA;
            end else if (state_q == DATA && bit_cnt_q == 5'd31) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q     <= '0;
            cmd_q         <= '0;
            data_q        <= '0;
            commit_q      <= 1'b0;
            rd_loaded_q   <= 1'b0;
            miso_sr_q     <= '0;
            buy_limit     <= '0;
            sell_limit    <= '0;
            buy_qty       <= '0;
            sell_qty      <= '0;
            exec_mode     <= MODE_BUILTIN;
            arb_mult      <= ARB_MULT_RST;
            cfg_wr_strobe <= 1'b0;
            cfg_wr_addr   <= '0;
            frame_err     <= 1'b0;
        end else begin
            cfg_wr_strobe <= 1'b0;

            // Commit cycle: the clk after the 40th bit was sampled.
            if (commit_q) begin
                commit_q <= 1'b0;
                if (!cmd_rd) begin
                    if (wr_ok) begin
                        case (cmd_idx)
                            REG_BUY_LIMIT:  buy_limit  <= data_q;
                            REG_SELL_LIMIT: sell_limit <= data_q;
                            REG_BUY_QTY:    buy_qty    <= data_q;
                            REG_SELL_QTY:   sell_qty   <= data_q;
                            REG_EXEC_MODE:  exec_mode  <= data_q[7:0];
                            REG_ARB_MULT:   arb_mult   <= data_q[15:0];
                            default:        ;
                        endcase
                        cfg_wr_strobe <= 1'b1;
                        cfg_wr_addr   <= {1'b0, cmd_idx};
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end

            if (cs_rise) begin
                bit_cnt_q   <= '0;
                rd_loaded_q <= 1'b0;
                if (state_q == CMD || state_q == DATA) begin
                    frame_err <= 1'b1;
                end
            end else if (cs_fall) begin
                bit_cnt_q   <= '0;
                rd_loaded_q <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    case (state_q)
                        CMD: begin
                            cmd_q     <= {cmd_q[6:0], mosi_s};
                            bit_cnt_q <= (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                        end
                        DATA: begin
                            data_q    <= {data_q[30:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd31) begin
                                commit_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                // First falling edge of a read data phase loads the shadow
                // word; later falling edges shift it out MSB first.
                if (sclk_fall && state_q == DATA && cmd_rd) begin
                    if (!rd_loaded_q) begin
                        miso_sr_q   <= rd_word;
                        rd_loaded_q <= 1'b1;
                    end else begin
                        miso_sr_q <= {miso_sr_q[30:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso = (state_q == DATA) && cmd_rd && rd_loaded_q && miso_sr_q[31];

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Testbench for spi_cfg_slave: directed frames followed by random frames,
// checked against a register-level model of the host-visible behaviour.
`timescale 1ns/1ps
module tb_spi_cfg_slave;

    localparam int H = 6; // clk cycles per SPI half period

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] buy_limit, sell_limit, buy_qty, sell_qty;
    logic [7:0]  exec_mode;
    logic [15:0] arb_mult;
    logic        cfg_wr_strobe;
    logic [7:0]  cfg_wr_addr;
    logic        frame_err;

    spi_cfg_slave #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .buy_limit     (buy_limit),
        .sell_limit    (sell_limit),
        .buy_qty       (buy_qty),
        .sell_qty      (sell_qty),
        .exec_mode     (exec_mode),
        .arb_mult      (arb_mult),
        .cfg_wr_strobe (cfg_wr_strobe),
        .cfg_wr_addr   (cfg_wr_addr),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register file, sticky error, expected strobe of the
    // last frame.
    logic [31:0] m_reg [0:5];
    logic        m_err;
    int          exp_strobe;
    logic [7:0]  exp_addr;
    logic [31:0] exp_rd;

    logic [7:0]  got_addr_q [$];

    always @(negedge clk) begin
        if (cfg_wr_strobe !== 1'b0) got_addr_q.push_back(cfg_wr_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = 32'd0;
        m_reg[5]   = 32'd16;
        m_err      = 1'b0;
        exp_strobe = 0;
        exp_addr   = 8'd0;
    endtask

    // Expected effect of one frame, from the register map rules.
    task automatic model_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits);
        int idx;
        idx        = int'(cmd[6:0]);
        exp_strobe = 0;
        exp_rd     = 32'd0;
        if (nbits < 40) begin
            m_err = 1'b1;
        end else if (cmd[7]) begin
            exp_rd = (idx <= 5) ? m_reg[idx] : 32'd0;
        end else if (idx > 5) begin
            m_err = 1'b1;
        end else if (idx == 4 && data[7:0] > 8'd2) begin
            m_err = 1'b1;
        end else begin
            if (idx == 4)      m_reg[idx] = data & 32'h0000_00FF;
            else if (idx == 5) m_reg[idx] = data & 32'h0000_FFFF;
            else               m_reg[idx] = data;
            exp_strobe = 1;
            exp_addr   = 8'(idx);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                            input bit raise_cs, output logic [31:0] rd, output int cmd_ones);
        logic [39:0] frame;
        frame    = {cmd, data};
        rd       = 32'd0;
        cmd_ones = 0;
        spi_cs_n = 1'b0;
        wclk(H);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 40) ? frame[39-i] : 1'($urandom_range(0, 1));
            wclk(H);
            if (i < 8) begin
                if (spi_miso !== 1'b0) cmd_ones++;
            end else if (i < 40) begin
                rd = {rd[30:0], spi_miso};
            end
            spi_sclk = 1'b1;
            wclk(H);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        if (raise_cs) begin
            wclk(H);
            spi_cs_n = 1'b1;
            wclk(2 * H);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/buy_limit"},  buy_limit,  m_reg[0]);
        chk({tag, "/sell_limit"}, sell_limit, m_reg[1]);
        chk({tag, "/buy_qty"},    buy_qty,    m_reg[2]);
        chk({tag, "/sell_qty"},   sell_qty,   m_reg[3]);
        chk({tag, "/exec_mode"},  {24'd0, exec_mode}, m_reg[4]);
        chk({tag, "/arb_mult"},   {16'd0, arb_mult},  m_reg[5]);
        chk({tag, "/frame_err"},  {31'd0, frame_err}, {31'd0, m_err});
        chk({tag, "/strobes"},    got_addr_q.size(), exp_strobe);
        if (exp_strobe == 1 && got_addr_q.size() == 1)
            chk({tag, "/wr_addr"}, {24'd0, got_addr_q[0]}, {24'd0, exp_addr});
        got_addr_q.delete();
    endtask

    task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [31:0] data,
                            input int nbits);
        logic [31:0] rd;
        int          ones;
        model_frame(cmd, data, nbits);
        spi_xfer(cmd, data, nbits, 1'b1, rd, ones);
        check_all(tag);
        chk({tag, "/miso_cmd"}, ones, 0);
        if (cmd[7] && nbits >= 40) chk({tag, "/rd"}, rd, exp_rd);
        chk({tag, "/miso_idle"}, {31'd0, spi_miso}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        wclk(3);
        rst_n = 1'b1;
        wclk(3);
        model_reset();
        check_all(tag);
        chk({tag, "/miso"}, {31'd0, spi_miso}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          ones;
        int          idx, sel, nb;
        logic [31:0] d;
        logic [7:0]  c;

        model_reset();
        do_reset("reset");

        // Single write, then a sequence of three writes.
        do_frame("w_buy_limit",  8'h00, 32'd42500, 40);
        do_frame("w_sell_limit", 8'h01, 32'd45000, 40);
        do_frame("w_sell_qty",   8'h03, 32'd2, 40);
        do_frame("w_exec_mode",  8'h04, 32'h0000_0002, 40);

        // Width truncation of arb_mult, then read-back.
        do_frame("w_arb_mult",   8'h05, 32'hFFFF_0012, 40);
        do_frame("r_arb_mult",   8'h85, 32'd0, 40);
        do_frame("r_buy_limit",  8'h80, 32'd0, 40);

        // Aborted frame.
        do_frame("abort20",      8'h02, 32'd3, 20);

        // Reset in the middle of a frame.
        do_reset("reset2");
        do_frame("w_buy_limit2", 8'h00, 32'd42500, 40);
        spi_xfer(8'h02, 32'd3, 20, 1'b0, rd, ones);
        do_reset("reset_mid");
        do_frame("w_buy_qty",    8'h02, 32'd3, 40);

        // Invalid exec_mode value and invalid index, each from a clean state.
        do_reset("reset3");
        do_frame("bad_mode",     8'h04, 32'h0000_0007, 40);
        do_reset("reset4");
        do_frame("bad_index",    8'h09, 32'd1, 40);
        do_frame("r_bad_index",  8'h8A, 32'd0, 40);
        do_reset("reset5");

        // Extra bits after the 40th are ignored; exactly one commit.
        do_frame("w_long",       8'h01, 32'h1234_5678, 45);
        do_frame("r_long",       8'h81, 32'd0, 40);

        // Random frames.
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 7);
            c   = {1'($urandom_range(0, 3) == 0), 7'(idx)};
            d   = $urandom;
            if (idx == 4) d[7:0] = 8'($urandom_range(0, 5));
            sel = $urandom_range(0, 9);
            if (sel == 0)      nb = $urandom_range(0, 39);
            else if (sel == 1) nb = $urandom_range(41, 46);
            else               nb = 40;
            do_frame($sformatf("rnd%0d", n), c, d, nb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cfg_slave.md
SPI_CFG_SLAVE -- requirements
Module: spi_cfg_slave

Interface
REQ-001 SYNC_STAGES, 2, number of synchronizer flops on spi_sclk, spi_mosi and spi_cs_n (minimum 2).
REQ-002 clk  input  1  core clock (1 GHz); single clock domain for all logic.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 spi_sclk  input  1  SPI clock (mode 0, ≤ clk/8), asynchronous to clk.
REQ-005 spi_cs_n  input  1  chip select, active-low; frames a transaction.
REQ-006 spi_mosi  input  1  host-to-slave data, MSB first.
REQ-007 spi_miso  output  1  slave-to-host read data, MSB first.
REQ-008 buy_limit / sell_limit  output  32 each  host limit prices.
REQ-009 buy_qty / sell_qty  output  32 each  host quantities.
REQ-010 exec_mode  output  8  0x00 built-in strategy, 0x01 host buy, 0x02 host sell.
REQ-011 arb_mult  output  16  built-in arbitrage multiplier.
REQ-012 cfg_wr_strobe  output  1  one-clk pulse on every committed register write.
REQ-013 cfg_wr_addr  output  8  register address of the write flagged by cfg_wr_strobe.
REQ-014 frame_err  output  1  sticky; set on an aborted or invalid frame; cleared only by reset.

Function
REQ-015 spi_sclk, spi_mosi and spi_cs_n SHALL pass through SYNC_STAGES flops; sclk rise/fall edges are detected in the clk domain.
REQ-016 Frame: 8-bit command, then 32 data bits; bit sampled on each synchronized sclk rising edge while cs_n is low.
REQ-017 Command bit7 = read flag; bits[6:0] = register index; 0x00 buy_limit, 0x01 sell_limit, 0x02 buy_qty, 0x03 sell_qty, 0x04 exec_mode, 0x05 arb_mult.
REQ-018 FSM states: IDLE, CMD, DATA, DONE. cs_n fall: IDLE->CMD with bit counter=0. 8th CMD bit: ->DATA. 32nd DATA bit: ->DONE. cs_n rise: any state ->IDLE.
REQ-019 Write commit: on the clk cycle after the 40th sampled bit, the target register loads; cfg_wr_strobe=1 and cfg_wr_addr=index for exactly that cycle.
REQ-020 Width rules: exec_mode takes data[7:0] and arb_mult takes data[15:0]; upper bits are ignored; 32-bit registers take the full word.
REQ-021 exec_mode write with value > 0x02: register unchanged, no strobe, frame_err set.
REQ-022 Write to index > 0x05: ignored, no strobe, frame_err set.
REQ-023 Read: on the sclk falling edge after the 8th command bit, the shadow copy of the indexed register (zero-extended to 32 bits; 0 for an invalid index) is loaded. Its MSB drives spi_miso; each subsequent falling edge shifts the next bit.
REQ-024 spi_miso SHALL be 0 outside the DATA state of a read frame.
REQ-025 cs_n rising before 40 bits: frame discarded, no register change, no strobe, frame_err set.
REQ-026 Bits beyond 40 in DONE are ignored until cs_n rises; only one commit per frame.
REQ-027 cs_n falling while in DONE, or with no IDLE in between, SHALL start a fresh frame.
REQ-028 Registers are readable on outputs continuously; an output changes only in the commit cycle.

Reset
REQ-029 rst_n low SHALL set: FSM IDLE, counters 0, limits/qtys 0, exec_mode 0x00, arb_mult 16, cfg_wr_strobe 0, cfg_wr_addr 0, frame_err 0, spi_miso 0, synchronizer flops to idle (sclk 0, cs_n 1, mosi 0).
REQ-030 Reset mid-frame SHALL abandon the frame; the first frame after reset requires a new cs_n fall.

Structure
REQ-031 Package hft_cfg_pkg holds register index constants, the exec_mode enum (MODE_BUILTIN, MODE_HOST_BUY, MODE_HOST_SELL), the arb_mult reset value, and the FSM state typedef.
REQ-032 One sub-module, spi_sync_edge, provides synchronizer and edge detect (instantiated for sclk and cs_n; mosi is synchronized only).

Verification
REQ-033 Write 0x00/42500 -> buy_limit=42500; one strobe with cfg_wr_addr=0x00; all other registers unchanged.
REQ-034 Writes 0x01/45000, 0x03/2, 0x04/0x02 -> sell_limit=45000, sell_qty=2, exec_mode=0x02; three strobes, in order.
REQ-035 Write 0x05/0xFFFF0012 -> arb_mult=18; then read 0x85 -> MISO returns 0x00000012.
REQ-036 cs_n rises after 20 bits of write 0x02/3 -> buy_qty stays 0, no strobe, frame_err=1.
REQ-037 Write 0x04/0x07 and write 0x09/1 -> no register change, no strobe, frame_err=1.
REQ-038 rst_n pulsed mid-frame after 0x00/42500 committed -> all outputs at reset values; next full write 0x02/3 succeeds.
